// File: rtl/ds_operand_scoreboard.sv
`default_nettype none
// ==========================================================================
// ds_operand_scoreboard -- decode operand forwarding + pending-write scoreboard
// Rev 1.0 | optional macro SB_PERF_CNT_EN adds the stall_cycles counter
// ==========================================================================
module ds_operand_scoreboard #(
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 3,
  parameter int XLEN    = 32,
  parameter int CNT_W   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_SRC-1:0]      src_used,
  input  logic [NUM_SRC*5-1:0]    src_addr,
  input  logic [NUM_SRC*XLEN-1:0] rf_rdata,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD*5-1:0]    fwd_dest,
  input  logic [NUM_FWD*XLEN-1:0] fwd_value,
  input  logic [NUM_FWD-1:0]      fwd_ready,
  input  logic                    issue_fire,
  input  logic                    issue_we,
  input  logic [4:0]              issue_dest,
  input  logic                    wb_we,
  input  logic [4:0]              wb_addr,
  input  logic [XLEN-1:0]         wb_data,
  input  logic                    flush,
  output logic [NUM_SRC*XLEN-1:0] src_value,
  output logic [NUM_SRC-1:0]      src_stall,
  output logic                    ready_go,
  output logic [31:0]             sb_busy
`ifdef SB_PERF_CNT_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt      [32];
  logic [CNT_W-1:0] cnt_next [32];
  logic [31:0]      busy_next;
  logic [31:0]      inc_vec;
  logic [31:0]      dec_vec;
  logic             inc_en;
  logic             dec_en;
  logic             sat_stall;

  assign inc_en  = issue_fire & issue_we & (issue_dest != 5'd0);
  assign dec_en  = wb_we & (wb_addr != 5'd0);
  assign inc_vec = inc_en ? (32'd1 << issue_dest) : 32'd0;
  assign dec_vec = dec_en ? (32'd1 << wb_addr) : 32'd0;

  // An issue and a writeback to the same register cancel out; r0 is never counted.
  always_comb begin
    busy_next = '0;
    for (int r = 0; r < 32; r++) begin
      cnt_next[r] = cnt[r];
      if (flush) begin
        cnt_next[r] = CNT_ZERO;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        if (cnt[r] != CNT_MAX) cnt_next[r] = cnt[r] + CNT_ONE;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        if (cnt[r] != CNT_ZERO) cnt_next[r] = cnt[r] - CNT_ONE;
      end
      busy_next[r] = (cnt_next[r] != CNT_ZERO);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) cnt[r] <= CNT_ZERO;
      sb_busy <= '0;
    end else begin
      for (int r = 0; r < 32; r++) cnt[r] <= cnt_next[r];
      sb_busy <= busy_next;
    end
  end

  for (genvar p = 0; p < NUM_SRC; p++) begin : g_port
    logic [4:0]      addr;
    logic            hit;
    logic            stall;
    logic [XLEN-1:0] val;

    assign addr = src_addr[5*p +: 5];

    // Walk oldest to youngest so the lowest-index matching stage wins.
    always_comb begin
      hit   = 1'b0;
      stall = 1'b0;
      val   = rf_rdata[XLEN*p +: XLEN];
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
        if (fwd_valid[i] && (fwd_dest[5*i +: 5] == addr)) begin
          hit   = 1'b1;
          stall = ~fwd_ready[i];
          val   = fwd_value[XLEN*i +: XLEN];
        end
      end
      if (addr == 5'd0) begin
        stall = 1'b0;
        val   = '0;
      end else if (!hit) begin
        if (wb_we && (wb_addr == addr)) begin
          val = wb_data;
        end else if (cnt[addr] != CNT_ZERO) begin
          stall = 1'b1;
        end
      end
      if (!src_used[p]) stall = 1'b0;
    end

    assign src_value[XLEN*p +: XLEN] = val;
    assign src_stall[p]              = stall;
  end

  assign sat_stall = issue_we & (issue_dest != 5'd0) & (cnt[issue_dest] == CNT_MAX);
  assign ready_go  = ~(|src_stall) & ~sat_stall;

`ifdef SB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= 32'd0;
    end else if (!ready_go && (|src_used)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!flush) begin
        assert (!(dec_en && !inc_vec[wb_addr] && (cnt[wb_addr] == CNT_ZERO)));
      end
      assert (!(issue_fire && !ready_go));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ds_operand_scoreboard.sv
`default_nettype none
// tb_ds_operand_scoreboard -- table vectors, directed multi-cycle sequences and
// randomized traffic against a reference model of the operand/scoreboard rules.
module tb_ds_operand_scoreboard;

  localparam int CMAX = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  src_used;
  logic [9:0]  src_addr;
  logic [63:0] rf_rdata;
  logic [2:0]  fwd_valid;
  logic [14:0] fwd_dest;
  logic [95:0] fwd_value;
  logic [2:0]  fwd_ready;
  logic        issue_fire;
  logic        issue_we;
  logic [4:0]  issue_dest;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic [63:0] src_value;
  logic [1:0]  src_stall;
  logic        ready_go;
  logic [31:0] sb_busy;
`ifdef SB_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_m [32];

  ds_operand_scoreboard dut (
    .clk(clk), .reset(reset), .src_used(src_used), .src_addr(src_addr),
    .rf_rdata(rf_rdata), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
    .fwd_value(fwd_value), .fwd_ready(fwd_ready), .issue_fire(issue_fire),
    .issue_we(issue_we), .issue_dest(issue_dest), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .src_value(src_value), .src_stall(src_stall), .ready_go(ready_go),
    .sb_busy(sb_busy)
`ifdef SB_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [1:0]  used;
    logic [4:0]  a1, a0;
    logic [31:0] rd1, rd0;
    logic [2:0]  fv, fr;
    logic [4:0]  d2, d1, d0;
    logic [31:0] v2, v1, v0;
    logic [31:0] e1, e0;
    logic [1:0]  es;
    logic        erg;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    src_used = 2'b00; src_addr = 10'd0; rf_rdata = 64'd0;
    fwd_valid = 3'b000; fwd_dest = 15'd0; fwd_value = 96'd0; fwd_ready = 3'b111;
    issue_fire = 1'b0; issue_we = 1'b0; issue_dest = 5'd0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; flush = 1'b0;
  endtask

  // Reference: resolve each port from the rules using the model counters.
  task automatic model_eval(output logic [63:0] ev, output logic [1:0] es, output logic erg);
    ev = '0;
    es = '0;
    for (int p = 0; p < 2; p++) begin
      logic [4:0] a;
      logic       found;
      int         wbm;
      a = src_addr[5*p +: 5];
      found = 1'b0;
      ev[32*p +: 32] = rf_rdata[32*p +: 32];
      if (a == 5'd0) begin
        ev[32*p +: 32] = 32'd0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (!found && fwd_valid[i] && fwd_dest[5*i +: 5] == a) begin
            found = 1'b1;
            ev[32*p +: 32] = fwd_value[32*i +: 32];
            es[p] = ~fwd_ready[i];
          end
        end
        if (!found) begin
          wbm = (wb_we && wb_addr == a) ? 1 : 0;
          if (wbm == 1) ev[32*p +: 32] = wb_data;
          else if (cnt_m[a] > wbm) es[p] = 1'b1;
        end
      end
      if (!src_used[p]) es[p] = 1'b0;
    end
    erg = (es == 2'b00) && !(issue_we && issue_dest != 5'd0 && cnt_m[issue_dest] == CMAX);
  endtask

  task automatic model_update();
    logic inc, dec;
    if (flush) begin
      for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    end else begin
      inc = issue_fire && issue_we && issue_dest != 5'd0;
      dec = wb_we && wb_addr != 5'd0;
      if (!(inc && dec && issue_dest == wb_addr)) begin
        if (inc && cnt_m[issue_dest] < CMAX) cnt_m[issue_dest]++;
        if (dec && cnt_m[wb_addr] > 0) cnt_m[wb_addr]--;
      end
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    for (int r = 0; r < 32; r++) b[r] = (cnt_m[r] != 0);
    return b;
  endfunction

  initial begin
    logic [63:0] ev;
    logic [1:0]  es;
    logic        erg;
    int          cand [$];

    idle();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_sb_busy", {32'd0, sb_busy}, 64'd0);
    chk("reset_ready_go", {63'd0, ready_go}, 64'd1);
    cyc();

    //            name      used   a1     a0     rd1           rd0           fv      fr      d2     d1     d0     v2            v1            v0            e1            e0            es     erg
    tbl[0] = '{"base",       2'b11, 5'd5,  5'd3,  32'h11,       32'h22,       3'b000, 3'b111, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'h11,       32'h22,       2'b00, 1'b1};
    tbl[1] = '{"young_wins", 2'b01, 5'd0,  5'd5,  32'h0,        32'hDEAD,     3'b101, 3'b111, 5'd5,  5'd0,  5'd5,  32'hBBBB,     32'h0,        32'hAAAA,     32'h0,        32'hAAAA,     2'b00, 1'b1};
    tbl[2] = '{"old_only",   2'b01, 5'd0,  5'd5,  32'h0,        32'hDEAD,     3'b100, 3'b111, 5'd5,  5'd0,  5'd0,  32'hBBBB,     32'h0,        32'h0,        32'h0,        32'hBBBB,     2'b00, 1'b1};
    tbl[3] = '{"load_use",   2'b10, 5'd7,  5'd0,  32'h1234,     32'h0,        3'b001, 3'b110, 5'd0,  5'd0,  5'd7,  32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        2'b10, 1'b0};
    tbl[4] = '{"r0_never",   2'b11, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h1,        3'b111, 3'b000, 5'd0,  5'd0,  5'd0,  32'h9,        32'h9,        32'h9,        32'h0,        32'h0,        2'b00, 1'b1};
    tbl[5] = '{"unused_msk", 2'b01, 5'd7,  5'd3,  32'h0,        32'h33,       3'b001, 3'b000, 5'd0,  5'd0,  5'd7,  32'h0,        32'h0,        32'h0,        32'h0,        32'h33,       2'b00, 1'b1};
    tbl[6] = '{"mid_stage",  2'b11, 5'd8,  5'd9,  32'h1,        32'h99,       3'b011, 3'b111, 5'd0,  5'd8,  5'd10, 32'h0,        32'h8888,     32'hAAAA,     32'h8888,     32'h99,       2'b00, 1'b1};
    tbl[7] = '{"shadowed",   2'b10, 5'd8,  5'd0,  32'h1,        32'h0,        3'b110, 3'b101, 5'd8,  5'd8,  5'd0,  32'h2222,     32'h1111,     32'h0,        32'h0,        32'h0,        2'b10, 1'b0};

    for (int k = 0; k < 8; k++) begin
      idle();
      src_used = tbl[k].used; src_addr = {tbl[k].a1, tbl[k].a0};
      rf_rdata = {tbl[k].rd1, tbl[k].rd0};
      fwd_valid = tbl[k].fv; fwd_ready = tbl[k].fr;
      fwd_dest = {tbl[k].d2, tbl[k].d1, tbl[k].d0};
      fwd_value = {tbl[k].v2, tbl[k].v1, tbl[k].v0};
      @(negedge clk);
      chk({tbl[k].name, "_stall"}, {62'd0, src_stall}, {62'd0, tbl[k].es});
      chk({tbl[k].name, "_ready_go"}, {63'd0, ready_go}, {63'd0, tbl[k].erg});
      if (tbl[k].used[0] && !tbl[k].es[0]) chk({tbl[k].name, "_val0"}, {32'd0, src_value[31:0]}, {32'd0, tbl[k].e0});
      if (tbl[k].used[1] && !tbl[k].es[1]) chk({tbl[k].name, "_val1"}, {32'd0, src_value[63:32]}, {32'd0, tbl[k].e1});
      cyc();
    end

    // Load-use resolves once the stage value becomes final
    idle();
    src_used = 2'b10; src_addr = {5'd7, 5'd0}; fwd_valid = 3'b001; fwd_dest = {5'd0, 5'd0, 5'd7};
    fwd_ready = 3'b110;
    @(negedge clk);
    chk("lu_stall", {62'd0, src_stall}, 64'h2);
    chk("lu_rg0", {63'd0, ready_go}, 64'd0);
    cyc();
    fwd_ready = 3'b111; fwd_value = {32'd0, 32'd0, 32'h5};
    @(negedge clk);
    chk("lu_rg1", {63'd0, ready_go}, 64'd1);
    chk("lu_val", {32'd0, src_value[63:32]}, 64'h5);
    cyc();

    // Long-latency producer on r9
    idle();
    issue_fire = 1'b1; issue_we = 1'b1; issue_dest = 5'd9;
    @(negedge clk);
    chk("ll_issue_rg", {63'd0, ready_go}, 64'd1);
    cyc();
    idle();
    src_used = 2'b10; src_addr = {5'd9, 5'd0}; rf_rdata = {32'hDEAD, 32'd0};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ll_stall", {62'd0, src_stall}, 64'h2);
      chk("ll_rg0", {63'd0, ready_go}, 64'd0);
      chk("ll_busy", {32'd0, sb_busy}, 64'h200);
      cyc();
    end
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h77;
    @(negedge clk);
    chk("ll_wb_val", {32'd0, src_value[63:32]}, 64'h77);
    chk("ll_wb_rg", {63'd0, ready_go}, 64'd1);
    cyc();
    wb_we = 1'b0;
    @(negedge clk);
    chk("ll_busy_clr", {32'd0, sb_busy}, 64'd0);
    chk("ll_after_val", {32'd0, src_value[63:32]}, 64'hDEAD);
    chk("ll_after_stall", {62'd0, src_stall}, 64'd0);
    cyc();

    // Counter saturation on r4
    idle();
    issue_fire = 1'b1; issue_we = 1'b1; issue_dest = 5'd4;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("sat_fill_rg", {63'd0, ready_go}, 64'd1);
      cyc();
    end
    issue_fire = 1'b0;
    @(negedge clk);
    chk("sat_stall", {63'd0, ready_go}, 64'd0);
    chk("sat_busy", {32'd0, sb_busy}, 64'h10);
    cyc();
    issue_we = 1'b0; wb_we = 1'b1; wb_addr = 5'd4;
    @(negedge clk);
    chk("sat_wb_rg", {63'd0, ready_go}, 64'd1);
    cyc();
    issue_fire = 1'b1; issue_we = 1'b1; issue_dest = 5'd4;
    @(negedge clk);
    chk("sat_both_rg", {63'd0, ready_go}, 64'd1);
    cyc();
    wb_we = 1'b0; issue_fire = 1'b0;
    @(negedge clk);
    chk("sat_both_hold", {63'd0, ready_go}, 64'd1);
    cyc();
    issue_fire = 1'b1;
    @(negedge clk);
    chk("sat_refill_rg", {63'd0, ready_go}, 64'd1);
    cyc();
    issue_fire = 1'b0;
    @(negedge clk);
    chk("sat_full_again", {63'd0, ready_go}, 64'd0);
    cyc();

    // Flush with pending r2, r6 (and r4) plus a same-cycle writeback
    idle();
    issue_fire = 1'b1; issue_we = 1'b1; issue_dest = 5'd2;
    cyc();
    issue_dest = 5'd6;
    cyc();
    idle();
    src_used = 2'b11; src_addr = {5'd2, 5'd6}; rf_rdata = {32'h2222, 32'h6666};
    @(negedge clk);
    chk("fl_pre_stall", {62'd0, src_stall}, 64'h3);
    chk("fl_pre_busy", {32'd0, sb_busy}, 64'h54);
    cyc();
    flush = 1'b1; wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'h5555;
    cyc();
    flush = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    chk("fl_busy", {32'd0, sb_busy}, 64'd0);
    chk("fl_stall", {62'd0, src_stall}, 64'd0);
    chk("fl_vals", src_value, {32'h2222, 32'h6666});
    chk("fl_rg", {63'd0, ready_go}, 64'd1);
    cyc();

    // Randomized traffic against the model
    idle();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    for (int c = 0; c < 2000; c++) begin
      src_used  = 2'($urandom_range(0, 3));
      src_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rf_rdata  = {$urandom, $urandom};
      fwd_valid = 3'($urandom_range(0, 7));
      fwd_dest  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_value = {$urandom, $urandom, $urandom};
      for (int i = 0; i < 3; i++) fwd_ready[i] = ($urandom_range(0, 3) != 0);
      cand.delete();
      for (int r = 1; r < 32; r++) if (cnt_m[r] > 0) cand.push_back(r);
      wb_we = 1'b0; wb_addr = 5'd0;
      if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
        wb_we = 1'b1;
        wb_addr = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      end
      wb_data    = $urandom;
      flush      = ($urandom_range(0, 39) == 0);
      issue_we   = $urandom_range(0, 1) == 1;
      issue_dest = 5'($urandom_range(0, 7));
      issue_fire = 1'b0;
      model_eval(ev, es, erg);
      issue_fire = erg && ($urandom_range(0, 1) == 1);
      @(negedge clk);
      chk("rnd_busy", {32'd0, sb_busy}, {32'd0, model_busy()});
      chk("rnd_stall", {62'd0, src_stall}, {62'd0, es});
      chk("rnd_ready_go", {63'd0, ready_go}, {63'd0, erg});
      for (int p = 0; p < 2; p++)
        if (src_used[p] && !es[p])
          chk($sformatf("rnd_val%0d", p), {32'd0, src_value[32*p +: 32]}, {32'd0, ev[32*p +: 32]});
      @(posedge clk);
      model_update();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
